us_tof_sequencer: RTL and testbench
===================================

US_TOF_SEQUENCER -- requirements
Module: us_tof_sequencer

Interface
REQ-001 SHALL have parameter: CLOCK_SPEED_HZ, 50_000_000, clock frequency (documentation only; timebase is 20 ns/cycle).
REQ-002 SHALL have parameter: N_ECHO, 2, number of echo input channels (fixed at 2 in this revision).
REQ-003 Ports, in order:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- time_cnt  in  32  free-running RTC count (+1/cycle, wraps)
- echo_in  in  2  asynchronous receiver echo pulses
- avalon_slave_address  in  16  register select = address>>8
- avalon_slave_write  in  1  write strobe
- avalon_slave_writedata  in  32  write data
- avalon_slave_read  in  1  read strobe
- avalon_slave_readdata  out  32  read data
- avalon_slave_waitrequest  out  1  stall
- piezo_enable  out  1  transmit burst gate
- busy  out  1  high whenever FSM not IDLE
- irq  out  1  level interrupt = STATUS.done & CTRL.irq_en

Function
REQ-004 Register map (address>>8): 0x00 CTRL RW {bit0 arm (self-clearing), bit1 abort (self-clearing), bit2 irq_en}; 0x01 START_TIME RW; 0x02 BURST_LEN RW (cycles); 0x03 LISTEN_LEN RW (cycles); 0x04 STATUS R {bit0 done, bit1 rx0_valid, bit2 rx1_valid, bit3 timeout, bits7:4 state}; 0x05 TX_STAMP R; 0x06 RX0_STAMP R; 0x07 RX1_STAMP R; 0x08 TOF0 R; 0x09 TOF1 R; other addresses read 32'hDEADBEEF, writes ignored.
REQ-005 Reads SHALL insert exactly one wait cycle: waitrequest = read & !rd_ready; readdata valid in the cycle waitrequest drops.
REQ-006 Writes SHALL never stall; a write SHALL take effect on the clock edge where write is high.
REQ-007 FSM states: IDLE, WAIT_START, FIRE, LISTEN, DONE.
REQ-008 IDLE -> WAIT_START on CTRL.arm write; arm clears done, rx*_valid, timeout.
REQ-009 WAIT_START -> FIRE when (time_cnt - START_TIME) bit31 == 0 (wrap-safe compare); a START_TIME already in the past fires next cycle.
REQ-010 On entry to FIRE: TX_STAMP <= time_cnt, piezo_enable SHALL be registered high for exactly BURST_LEN cycles; BURST_LEN==0 SHALL be treated as 1.
REQ-011 FIRE -> LISTEN after burst; LISTEN lasts LISTEN_LEN cycles, then -> DONE; LISTEN_LEN==0 -> DONE immediately with timeout=1.
REQ-012 echo_in SHALL pass a 2-FF synchronizer plus rising-edge detect (3-cycle latency); only the first edge per channel during LISTEN is captured: RXn_STAMP <= time_cnt, rxn_valid <= 1; edges outside LISTEN are ignored.
REQ-013 Both channels SHALL be captured independently when edges coincide in the same cycle.
REQ-014 LISTEN SHALL exit early to DONE once all channels are valid; timeout=1 if LISTEN expires with any channel invalid.
REQ-015 TOFn SHALL equal RXn_STAMP - TX_STAMP modulo 2^32 (correct across wrap); 0 if rxn_valid=0.
REQ-016 DONE sets done=1 and returns to IDLE next cycle; results hold until next arm.
REQ-017 Arm while busy SHALL be ignored; START_TIME/BURST_LEN/LISTEN_LEN writes while busy SHALL be ignored.
REQ-018 Abort in any state SHALL drop piezo_enable next cycle, go IDLE, leave done=0, keep stamps.

Reset
REQ-019 Reset SHALL force: state IDLE, piezo_enable 0, busy 0, irq 0, readdata 0, waitrequest 0 when read low, all registers and stamps 0, synchronizers 0.
REQ-020 Reset asserted mid-burst SHALL deassert piezo_enable asynchronously.

Structure
REQ-021 State encoding and register-address constants SHALL live in shared package us_tof_pkg.
REQ-022 Echo synchronizer + edge detect SHALL be sub-module echo_edge_sync (one instance per channel).

Verification
REQ-023 START_TIME=1000, BURST_LEN=8, LISTEN_LEN=500, echo0 edge at time 1200 -> piezo high 8 cycles from time 1000, TX_STAMP=1000, RX0_STAMP=1203, TOF0=203, timeout=1 (rx1 missing).
REQ-024 START_TIME=0xFFFFFFF0, time_cnt near wrap, echo at 0x10 -> fire at 0xFFFFFFF0, TOF0=0x23 (includes sync latency).
REQ-025 Both echoes in same cycle -> rx0_valid=rx1_valid=1, equal stamps, early DONE, timeout=0, irq=1 if irq_en.
REQ-026 Abort at burst cycle 3 -> piezo_enable low next cycle, state IDLE, done=0.
REQ-027 Read of 0x04 -> waitrequest high one cycle, then STATUS; read of 0x0A -> 32'hDEADBEEF.
REQ-028 Reset asserted during FIRE -> piezo_enable 0 immediately, all registers 0.

Source files
------------

// File: rtl/us_tof_pkg.sv
`default_nettype none
// ============================================================================
// Module      : us_tof_pkg
// Description : Shared state encoding and register map for the ultrasonic
//               time-of-flight sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package us_tof_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_WAIT_START = 4'd1,
        ST_FIRE       = 4'd2,
        ST_LISTEN     = 4'd3,
        ST_DONE       = 4'd4
    } state_t;

    // Register select values (bus address >> 8)
    localparam logic [7:0] REG_CTRL       = 8'h00;
    localparam logic [7:0] REG_START_TIME = 8'h01;
    localparam logic [7:0] REG_BURST_LEN  = 8'h02;
    localparam logic [7:0] REG_LISTEN_LEN = 8'h03;
    localparam logic [7:0] REG_STATUS     = 8'h04;
    localparam logic [7:0] REG_TX_STAMP   = 8'h05;
    localparam logic [7:0] REG_RX0_STAMP  = 8'h06;
    localparam logic [7:0] REG_RX1_STAMP  = 8'h07;
    localparam logic [7:0] REG_TOF0       = 8'h08;
    localparam logic [7:0] REG_TOF1       = 8'h09;

    // CTRL bit positions
    localparam int CTRL_ARM    = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

    // Value returned for unmapped register reads
    localparam logic [31:0] READ_DEFAULT = 32'hDEADBEEF;

endpackage
`default_nettype wire

// File: rtl/us_tof_sequencer_echo_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : echo_edge_sync
// Description : Two-flop synchronizer for an asynchronous echo pulse followed
//               by a registered rising-edge detector (3-cycle latency).
// Revision    : 1.0 - initial release
// ============================================================================
module echo_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic echo_async,
    output logic rise_pulse
);

    logic sync_meta;
    logic sync_stable;
    logic sync_prev;

    // Synchronize, then register a one-cycle pulse on each 0->1 transition
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_meta   <= 1'b0;
            sync_stable <= 1'b0;
            sync_prev   <= 1'b0;
            rise_pulse  <= 1'b0;
        end else begin
            sync_meta   <= echo_async;
            sync_stable <= sync_meta;
            sync_prev   <= sync_stable;
            rise_pulse  <= sync_stable && !sync_prev;
        end
    end

endmodule
`default_nettype wire

// File: rtl/us_tof_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : us_tof_sequencer
// Description : Schedules a piezo transmit burst at an RTC time, listens for
//               echoes on two receivers, timestamps them and reports TOF via
//               an Avalon-MM slave.
// Revision    : 1.0 - initial release
// ============================================================================
module us_tof_sequencer
    import us_tof_pkg::*;
#(
    parameter int CLOCK_SPEED_HZ = 50_000_000,
    parameter int N_ECHO         = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] time_cnt,
    input  logic [1:0]  echo_in,
    input  logic [15:0] avalon_slave_address,
    input  logic        avalon_slave_write,
    input  logic [31:0] avalon_slave_writedata,
    input  logic        avalon_slave_read,
    output logic [31:0] avalon_slave_readdata,
    output logic        avalon_slave_waitrequest,
    output logic        piezo_enable,
    output logic        busy,
    output logic        irq
);

    state_t            state;
    state_t            state_next;
    logic [31:0]       start_time;
    logic [31:0]       burst_len;
    logic [31:0]       listen_len;
    logic [31:0]       phase_cnt;
    logic [31:0]       tx_stamp;
    logic [31:0]       read_mux;
    logic [31:0]       start_delta;
    logic [31:0]       rx_stamp [N_ECHO];
    logic [31:0]       tof      [N_ECHO];
    logic [N_ECHO-1:0] rx_valid;
    logic [N_ECHO-1:0] rx_valid_next;
    logic [N_ECHO-1:0] capture;
    logic [N_ECHO-1:0] echo_rise;
    logic [7:0]        reg_sel;
    logic              irq_en;
    logic              done;
    logic              timeout;
    logic              rd_ready;
    logic              piezo_next;
    logic              wr_ctrl;
    logic              arm_req;
    logic              abort_req;
    logic              arm_accept;
    logic              cfg_wr_ok;
    logic              fire_entry;
    logic              unused_ok;

    assign reg_sel       = avalon_slave_address[15:8];
    assign wr_ctrl       = avalon_slave_write && (reg_sel == REG_CTRL);
    assign arm_req       = wr_ctrl && avalon_slave_writedata[CTRL_ARM];
    assign abort_req     = wr_ctrl && avalon_slave_writedata[CTRL_ABORT];
    assign arm_accept    = arm_req && !abort_req && (state == ST_IDLE);
    // Timing configuration is frozen while a measurement is in progress
    assign cfg_wr_ok     = avalon_slave_write && (state == ST_IDLE);
    // Wrap-safe "time_cnt has reached start_time" via sign of the difference
    assign start_delta   = time_cnt - start_time;
    assign fire_entry    = (state == ST_WAIT_START) && (state_next == ST_FIRE);
    assign rx_valid_next = rx_valid | capture;
    assign unused_ok     = ^{CLOCK_SPEED_HZ, avalon_slave_address[7:0]};

    generate
        for (genvar gi = 0; gi < N_ECHO; gi++) begin : g_echo
            echo_edge_sync u_sync (
                .clock      (clock),
                .reset      (reset),
                .echo_async (echo_in[gi]),
                .rise_pulse (echo_rise[gi])
            );
            assign capture[gi] = echo_rise[gi] && (state == ST_LISTEN)
                                 && !rx_valid[gi] && !abort_req;
            assign tof[gi]     = rx_valid[gi] ? (rx_stamp[gi] - tx_stamp) : 32'd0;
        end
    endgenerate

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state decode; abort overrides every state
    always_comb begin
        state_next = state;
        if (abort_req) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:       if (arm_req) state_next = ST_WAIT_START;
                ST_WAIT_START: if (!start_delta[31]) state_next = ST_FIRE;
                ST_FIRE:       if (phase_cnt == 32'd1)
                                   state_next = (listen_len == 32'd0) ? ST_DONE : ST_LISTEN;
                ST_LISTEN:     if ((&rx_valid_next) || (phase_cnt == 32'd1))
                                   state_next = ST_DONE;
                ST_DONE:       state_next = ST_IDLE;
                default:       state_next = ST_IDLE;
            endcase
        end
    end

    // Decoded outputs
    always_comb begin
        busy                     = (state != ST_IDLE);
        irq                      = done && irq_en;
        piezo_next               = (state_next == ST_FIRE);
        avalon_slave_waitrequest = avalon_slave_read && !rd_ready;
    end

    // Burst gate gets its own flop so the transducer drive is glitch-free
    always_ff @(posedge clock or posedge reset) begin
        if (reset) piezo_enable <= 1'b0;
        else       piezo_enable <= piezo_next;
    end

    // Burst/listen countdown and transmit timestamp
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_cnt <= '0;
            tx_stamp  <= '0;
        end else if (fire_entry) begin
            tx_stamp  <= time_cnt;
            phase_cnt <= (burst_len == 32'd0) ? 32'd1 : burst_len;
        end else if ((state == ST_FIRE) && (state_next == ST_LISTEN)) begin
            phase_cnt <= listen_len;
        end else if (((state == ST_FIRE) || (state == ST_LISTEN)) && (phase_cnt != 32'd0)) begin
            phase_cnt <= phase_cnt - 32'd1;
        end
    end

    // Configuration registers and result flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_en     <= 1'b0;
            start_time <= '0;
            burst_len  <= '0;
            listen_len <= '0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en <= avalon_slave_writedata[CTRL_IRQ_EN];
            if (cfg_wr_ok && (reg_sel == REG_START_TIME)) start_time <= avalon_slave_writedata;
            if (cfg_wr_ok && (reg_sel == REG_BURST_LEN))  burst_len  <= avalon_slave_writedata;
            if (cfg_wr_ok && (reg_sel == REG_LISTEN_LEN)) listen_len <= avalon_slave_writedata;
            if (arm_accept) begin
                done    <= 1'b0;
                timeout <= 1'b0;
            end else begin
                if ((state == ST_DONE) && !abort_req) done <= 1'b1;
                if ((state != ST_DONE) && (state_next == ST_DONE) && !(&rx_valid_next))
                    timeout <= 1'b1;
            end
        end
    end

    // Receive stamps: first edge per channel during LISTEN wins
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_valid <= '0;
            for (int i = 0; i < N_ECHO; i++) rx_stamp[i] <= '0;
        end else begin
            for (int i = 0; i < N_ECHO; i++) begin
                if (arm_accept) begin
                    rx_valid[i] <= 1'b0;
                end else if (capture[i]) begin
                    rx_valid[i] <= 1'b1;
                    rx_stamp[i] <= time_cnt;
                end
            end
        end
    end

    // Register read multiplexer
    always_comb begin
        read_mux = READ_DEFAULT;
        case (reg_sel)
            REG_CTRL:       read_mux = {29'd0, irq_en, 2'b00};
            REG_START_TIME: read_mux = start_time;
            REG_BURST_LEN:  read_mux = burst_len;
            REG_LISTEN_LEN: read_mux = listen_len;
            REG_STATUS:     read_mux = {24'd0, state, timeout, rx_valid[1], rx_valid[0], done};
            REG_TX_STAMP:   read_mux = tx_stamp;
            REG_RX0_STAMP:  read_mux = rx_stamp[0];
            REG_RX1_STAMP:  read_mux = rx_stamp[1];
            REG_TOF0:       read_mux = tof[0];
            REG_TOF1:       read_mux = tof[1];
            default:        ;
        endcase
    end

    // One wait cycle per read: data is registered while waitrequest is high
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ready              <= 1'b0;
            avalon_slave_readdata <= '0;
        end else begin
            rd_ready <= avalon_slave_read && !rd_ready;
            if (avalon_slave_read && !rd_ready) avalon_slave_readdata <= read_mux;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_us_tof_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_us_tof_sequencer
// Description : Self-checking bench for us_tof_sequencer; register reads are
//               checked against a queue of expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_us_tof_sequencer;
    import us_tof_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] time_cnt;
    logic [1:0]  echo_in;
    logic [15:0] avalon_slave_address;
    logic        avalon_slave_write;
    logic [31:0] avalon_slave_writedata;
    logic        avalon_slave_read;
    logic [31:0] avalon_slave_readdata;
    logic        avalon_slave_waitrequest;
    logic        piezo_enable;
    logic        busy;
    logic        irq;

    int          compared   = 0;
    int          mismatched = 0;
    logic [7:0]  addr_q [$];
    logic [31:0] exp_q  [$];
    logic [31:0] kept_rx0;

    always #10 clock = ~clock;

    us_tof_sequencer #(.CLOCK_SPEED_HZ(50_000_000), .N_ECHO(2)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .time_cnt                 (time_cnt),
        .echo_in                  (echo_in),
        .avalon_slave_address     (avalon_slave_address),
        .avalon_slave_write       (avalon_slave_write),
        .avalon_slave_writedata   (avalon_slave_writedata),
        .avalon_slave_read        (avalon_slave_read),
        .avalon_slave_readdata    (avalon_slave_readdata),
        .avalon_slave_waitrequest (avalon_slave_waitrequest),
        .piezo_enable             (piezo_enable),
        .busy                     (busy),
        .irq                      (irq)
    );

    // Advance one cycle; the RTC ticks 1 ns after each rising edge
    task automatic step();
        @(posedge clock);
        #1;
        time_cnt = time_cnt + 32'd1;
    endtask

    task automatic bus_write(input logic [7:0] r, input logic [31:0] data);
        avalon_slave_address   = {r, 8'h00};
        avalon_slave_writedata = data;
        avalon_slave_write     = 1'b1;
        step();
        avalon_slave_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] r, output logic [31:0] data, output int waits);
        avalon_slave_address = {r, 8'h00};
        avalon_slave_read    = 1'b1;
        waits = 0;
        data  = 'x;
        for (int n = 0; n < 6; n++) begin
            #2;
            if (!avalon_slave_waitrequest) begin
                data = avalon_slave_readdata;
                break;
            end
            waits++;
            step();
        end
        step();
        avalon_slave_read = 1'b0;
    endtask

    task automatic expect_read(input logic [7:0] r, input logic [31:0] e);
        addr_q.push_back(r);
        exp_q.push_back(e);
    endtask

    // Run until the sequencer is idle, pulsing the enabled echo channels for
    // 6 cycles starting when time_cnt equals echo_at
    task automatic run_until_idle(input int limit, input logic [1:0] echo_en,
                                  input logic [31:0] echo_at, output int piezo_cycles,
                                  output logic [31:0] idle_at, output bit ok);
        piezo_cycles = 0;
        idle_at      = '0;
        ok           = 1'b0;
        for (int n = 0; n < limit; n++) begin
            echo_in = echo_en & {2{((time_cnt - echo_at) < 32'd6)}};
            if (piezo_enable) piezo_cycles++;
            if (!busy) begin
                idle_at = time_cnt;
                ok      = 1'b1;
                break;
            end
            step();
        end
        echo_in = 2'b00;
    endtask

    task automatic test_reset();
        logic [31:0] d, e;
        logic [7:0]  r;
        int          w;
        reset = 1'b1; time_cnt = '0; echo_in = '0;
        avalon_slave_address = '0; avalon_slave_write = 1'b0;
        avalon_slave_writedata = '0; avalon_slave_read = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        compared++;
        if ({piezo_enable, busy, irq, avalon_slave_waitrequest} !== 4'b0000) begin
            $display("FAIL reset_outputs: got %b expected 0000", {piezo_enable, busy, irq, avalon_slave_waitrequest});
            mismatched++;
        end
        compared++;
        if (avalon_slave_readdata !== 32'd0) begin
            $display("FAIL reset_readdata: got %h expected 00000000", avalon_slave_readdata);
            mismatched++;
        end
        reset = 1'b0;
        step();
        expect_read(REG_STATUS, 32'd0);
        expect_read(REG_START_TIME, 32'd0);
        expect_read(REG_TX_STAMP, 32'd0);
        while (addr_q.size() > 0) begin
            r = addr_q.pop_front(); e = exp_q.pop_front();
            bus_read(r, d, w);
            compared++;
            if (d !== e) begin
                $display("FAIL reset reg 0x%02h: got %h expected %h", r, d, e);
                mismatched++;
            end
        end
    endtask

    task automatic test_single_echo();
        logic [31:0] d, e, idle_at;
        logic [7:0]  r;
        int          w, pc;
        bit          ok;
        bus_write(REG_START_TIME, 32'd1000);
        bus_write(REG_BURST_LEN, 32'd8);
        bus_write(REG_LISTEN_LEN, 32'd500);
        time_cnt = 32'd950;
        bus_write(REG_CTRL, 32'h1);
        expect_read(REG_TX_STAMP, 32'd1000);
        expect_read(REG_RX0_STAMP, 32'd1203);
        expect_read(REG_TOF0, 32'd203);
        expect_read(REG_TOF1, 32'd0);
        expect_read(REG_STATUS, 32'hB);
        run_until_idle(2000, 2'b01, 32'd1200, pc, idle_at, ok);
        compared++;
        if (!ok) begin $display("FAIL single_echo timeout: busy never dropped"); mismatched++; end
        compared++;
        if (pc !== 8) begin $display("FAIL single_echo burst_cycles: got %0d expected 8", pc); mismatched++; end
        compared++;
        if (irq !== 1'b0) begin $display("FAIL single_echo irq: got %b expected 0", irq); mismatched++; end
        while (addr_q.size() > 0) begin
            r = addr_q.pop_front(); e = exp_q.pop_front();
            bus_read(r, d, w);
            compared++;
            if (d !== e) begin
                $display("FAIL single_echo reg 0x%02h: got %h expected %h", r, d, e);
                mismatched++;
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d, e, idle_at;
        logic [7:0]  r;
        int          w, pc;
        bit          ok;
        bus_write(REG_START_TIME, 32'hFFFF_FFF0);
        bus_write(REG_BURST_LEN, 32'd4);
        bus_write(REG_LISTEN_LEN, 32'd100);
        time_cnt = 32'hFFFF_FFD0;
        bus_write(REG_CTRL, 32'h1);
        expect_read(REG_TX_STAMP, 32'hFFFF_FFF0);
        expect_read(REG_RX0_STAMP, 32'h13);
        expect_read(REG_TOF0, 32'h23);
        expect_read(REG_STATUS, 32'hB);
        run_until_idle(400, 2'b01, 32'h10, pc, idle_at, ok);
        compared++;
        if (!ok || pc !== 4) begin
            $display("FAIL wrap_run: got ok=%0d burst=%0d expected ok=1 burst=4", ok, pc);
            mismatched++;
        end
        while (addr_q.size() > 0) begin
            r = addr_q.pop_front(); e = exp_q.pop_front();
            bus_read(r, d, w);
            compared++;
            if (d !== e) begin
                $display("FAIL wrap reg 0x%02h: got %h expected %h", r, d, e);
                mismatched++;
            end
        end
    endtask

    task automatic test_both_echo();
        logic [31:0] d, e, idle_at, st, t_echo;
        logic [7:0]  r;
        int          w, pc;
        bit          ok;
        st     = time_cnt + 32'd30;
        t_echo = st + 32'd50;
        bus_write(REG_START_TIME, st);
        bus_write(REG_BURST_LEN, 32'd2);
        bus_write(REG_LISTEN_LEN, 32'd200);
        bus_write(REG_CTRL, 32'h5);
        bus_write(REG_BURST_LEN, 32'd99);
        kept_rx0 = t_echo + 32'd3;
        expect_read(REG_STATUS, 32'h7);
        expect_read(REG_RX0_STAMP, t_echo + 32'd3);
        expect_read(REG_RX1_STAMP, t_echo + 32'd3);
        expect_read(REG_TOF0, 32'd53);
        expect_read(REG_TOF1, 32'd53);
        expect_read(REG_BURST_LEN, 32'd2);
        expect_read(REG_CTRL, 32'h4);
        run_until_idle(400, 2'b11, t_echo, pc, idle_at, ok);
        compared++;
        if (!ok || idle_at !== t_echo + 32'd5) begin
            $display("FAIL both_early_done: got idle_at=%h ok=%0d expected %h", idle_at, ok, t_echo + 32'd5);
            mismatched++;
        end
        compared++;
        if (pc !== 2) begin $display("FAIL both_burst_cycles: got %0d expected 2", pc); mismatched++; end
        compared++;
        if (irq !== 1'b1) begin $display("FAIL both_irq: got %b expected 1", irq); mismatched++; end
        while (addr_q.size() > 0) begin
            r = addr_q.pop_front(); e = exp_q.pop_front();
            bus_read(r, d, w);
            compared++;
            if (d !== e) begin
                $display("FAIL both reg 0x%02h: got %h expected %h", r, d, e);
                mismatched++;
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] d, e, st;
        logic [7:0]  r;
        int          w, n;
        st = time_cnt + 32'd10;
        bus_write(REG_START_TIME, st);
        bus_write(REG_BURST_LEN, 32'd10);
        bus_write(REG_LISTEN_LEN, 32'd50);
        bus_write(REG_CTRL, 32'h5);
        n = 0;
        while (piezo_enable !== 1'b1 && n < 50) begin step(); n++; end
        compared++;
        if (n >= 50) begin $display("FAIL abort_fire: piezo never rose within 50 cycles"); mismatched++; end
        step();
        step();
        bus_write(REG_CTRL, 32'h6);
        compared++;
        if ({piezo_enable, busy, irq} !== 3'b000) begin
            $display("FAIL abort_outputs: got %b expected 000", {piezo_enable, busy, irq});
            mismatched++;
        end
        expect_read(REG_STATUS, 32'h0);
        expect_read(REG_TX_STAMP, st);
        expect_read(REG_RX0_STAMP, kept_rx0);
        expect_read(REG_TOF0, 32'h0);
        while (addr_q.size() > 0) begin
            r = addr_q.pop_front(); e = exp_q.pop_front();
            bus_read(r, d, w);
            compared++;
            if (d !== e) begin
                $display("FAIL abort reg 0x%02h: got %h expected %h", r, d, e);
                mismatched++;
            end
        end
    endtask

    task automatic test_zero_lengths();
        logic [31:0] d, e, idle_at;
        logic [7:0]  r;
        int          w, pc;
        bit          ok;
        bus_write(REG_START_TIME, 32'd0);
        bus_write(REG_BURST_LEN, 32'd0);
        bus_write(REG_LISTEN_LEN, 32'd0);
        bus_write(REG_CTRL, 32'h1);
        expect_read(REG_STATUS, 32'h9);
        expect_read(REG_TOF0, 32'h0);
        expect_read(REG_TOF1, 32'h0);
        run_until_idle(50, 2'b00, 32'd0, pc, idle_at, ok);
        compared++;
        if (!ok || pc !== 1) begin
            $display("FAIL zero_len_burst: got ok=%0d burst=%0d expected ok=1 burst=1", ok, pc);
            mismatched++;
        end
        while (addr_q.size() > 0) begin
            r = addr_q.pop_front(); e = exp_q.pop_front();
            bus_read(r, d, w);
            compared++;
            if (d !== e) begin
                $display("FAIL zero_len reg 0x%02h: got %h expected %h", r, d, e);
                mismatched++;
            end
        end
    endtask

    task automatic test_bus_reads();
        logic [31:0] d, e;
        logic [7:0]  r;
        int          w;
        bus_write(REG_LISTEN_LEN, 32'h0000_1234);
        bus_write(8'h0A, 32'h1111_1111);
        expect_read(8'h0A, READ_DEFAULT);
        expect_read(REG_STATUS, 32'h9);
        expect_read(REG_LISTEN_LEN, 32'h0000_1234);
        while (addr_q.size() > 0) begin
            r = addr_q.pop_front(); e = exp_q.pop_front();
            bus_read(r, d, w);
            compared++;
            if (d !== e) begin
                $display("FAIL bus reg 0x%02h: got %h expected %h", r, d, e);
                mismatched++;
            end
            compared++;
            if (w !== 1) begin
                $display("FAIL bus_wait reg 0x%02h: got %0d wait cycles expected 1", r, w);
                mismatched++;
            end
        end
    endtask

    task automatic test_reset_in_fire();
        logic [31:0] d, e;
        logic [7:0]  r;
        int          w, n;
        bus_write(REG_START_TIME, time_cnt + 32'd5);
        bus_write(REG_BURST_LEN, 32'd50);
        bus_write(REG_LISTEN_LEN, 32'd10);
        bus_write(REG_CTRL, 32'h5);
        n = 0;
        while (piezo_enable !== 1'b1 && n < 50) begin step(); n++; end
        step();
        step();
        compared++;
        if (piezo_enable !== 1'b1) begin
            $display("FAIL reset_fire_pre: got piezo %b expected 1", piezo_enable);
            mismatched++;
        end
        #5;
        reset = 1'b1;
        #1;
        compared++;
        if ({piezo_enable, busy, irq} !== 3'b000) begin
            $display("FAIL reset_fire_async: got %b expected 000", {piezo_enable, busy, irq});
            mismatched++;
        end
        step();
        reset = 1'b0;
        step();
        expect_read(REG_START_TIME, 32'd0);
        expect_read(REG_BURST_LEN, 32'd0);
        expect_read(REG_TX_STAMP, 32'd0);
        expect_read(REG_RX0_STAMP, 32'd0);
        expect_read(REG_STATUS, 32'd0);
        expect_read(REG_CTRL, 32'd0);
        while (addr_q.size() > 0) begin
            r = addr_q.pop_front(); e = exp_q.pop_front();
            bus_read(r, d, w);
            compared++;
            if (d !== e) begin
                $display("FAIL reset_fire reg 0x%02h: got %h expected %h", r, d, e);
                mismatched++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_echo();
        test_wrap();
        test_both_echo();
        test_abort();
        test_zero_lengths();
        test_bus_reads();
        test_reset_in_fire();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
